// File: rtl/firebird7_in_gate1_tessent_tdr_w3.sv
// -----------------------------------------------------------------------------
// firebird7_in_gate1_tessent_tdr_w3
//
// IJTAG test data register placed directly upstream of the 3-bit IJTAG data
// mux. A WIDTH+2 bit shift/capture register sits on the IJTAG scan path; an
// update stage with the same layout drives the mux select and data inputs.
// The topmost bit of the update stage is a sticky lock that freezes the
// update stage until ijtag_reset.
//
// Register layout (SR and UR alike):
//   [WIDTH+1] lock
//   [WIDTH]   select
//   [WIDTH-1:0] data
//
// Ports:
//   ijtag_tck          in   IJTAG clock; all state changes on the rising edge
//   ijtag_reset        in   asynchronous, active-high reset
//   ijtag_sel          in   this TDR is on the active scan path
//   ijtag_ce           in   capture enable (wins over shift)
//   ijtag_se           in   shift enable
//   ijtag_ue           in   update enable
//   ijtag_si           in   scan in (enters at the MSB)
//   ijtag_so           out  scan out, SR bit 0
//   functional_data_in in   functional value captured for observation
//   ijtag_select       out  update-stage select, to the mux select
//   ijtag_data_out     out  update-stage data, to the mux ijtag_data_in
//   tdr_locked         out  update-stage lock bit
// -----------------------------------------------------------------------------
module firebird7_in_gate1_tessent_tdr_w3 #(
  parameter int                WIDTH      = 3,
  parameter logic [WIDTH-1:0]  RESET_DATA = '0
) (
  input  logic             ijtag_tck,
  input  logic             ijtag_reset,
  input  logic             ijtag_sel,
  input  logic             ijtag_ce,
  input  logic             ijtag_se,
  input  logic             ijtag_ue,
  input  logic             ijtag_si,
  output logic             ijtag_so,
  input  logic [WIDTH-1:0] functional_data_in,
  output logic             ijtag_select,
  output logic [WIDTH-1:0] ijtag_data_out,
  output logic             tdr_locked
);

  localparam int SR_LEN  = WIDTH + 2;
  localparam int LOCK_IX = WIDTH + 1;
  localparam int SEL_IX  = WIDTH;

  // The lock is the only sequential control state of this block.
  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  logic [SR_LEN-1:0] r_sr;
  logic              r_ur_select;
  logic [WIDTH-1:0]  r_ur_data;
  lock_state_t       r_lock_state;

  logic w_capture;
  logic w_shift;
  logic w_update;
  logic w_locked;

  // Nothing happens unless the TDR is on the active scan path.
  assign w_capture = ijtag_sel & ijtag_ce;
  assign w_shift   = ijtag_sel & ijtag_se & ~ijtag_ce;
  assign w_update  = ijtag_sel & ijtag_ue;
  assign w_locked  = (r_lock_state == LOCKED);

  // ---------------------------------------------------------------------------
  // Shift / capture stage. Capture records the current update-stage control
  // bits alongside the functional value so the tool can read back lock and
  // select in the same scan.
  // ---------------------------------------------------------------------------
  // NOTE: every flop here, control and data alike, is cleared by the async
  // reset so the scan path and mux controls are defined the instant reset
  // asserts, even mid-shift.
  always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
    if (ijtag_reset) begin
      r_sr <= '0;
    end else if (w_capture) begin
      // NOTE: non-blocking assignment keeps the pre-edge r_sr visible to the
      // update stage below, so update+shift on one edge loads the old value.
      r_sr <= {w_locked, r_ur_select, functional_data_in};
    end else if (w_shift) begin
      r_sr <= {ijtag_si, r_sr[SR_LEN-1:1]};
    end
  end

  // ---------------------------------------------------------------------------
  // Update stage and lock state. Once locked, the whole update stage holds
  // (select and data too); only reset leaves LOCKED. A lock written together
  // with select/data takes effect in the same update.
  // ---------------------------------------------------------------------------
  always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
    if (ijtag_reset) begin
      r_ur_select  <= 1'b0;
      r_ur_data    <= RESET_DATA;
      r_lock_state <= UNLOCKED;
    end else begin
      case (r_lock_state)
        UNLOCKED: begin
          if (w_update) begin
            r_ur_select <= r_sr[SEL_IX];
            r_ur_data   <= r_sr[WIDTH-1:0];
            if (r_sr[LOCK_IX]) begin
              r_lock_state <= LOCKED;
            end
          end
        end
        LOCKED: begin
          // NOTE: flops simply hold when not assigned; in always_ff that is a
          // register enable, never a latch.
          r_lock_state <= LOCKED;
        end
        default: r_lock_state <= UNLOCKED;
      endcase
    end
  end

  // Outputs come straight from flops; no combinational path from SR.
  assign ijtag_so       = r_sr[0];
  assign ijtag_select   = r_ur_select;
  assign ijtag_data_out = r_ur_data;
  assign tdr_locked     = w_locked;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_tdr_w3.sv
// -----------------------------------------------------------------------------
// Testbench for firebird7_in_gate1_tessent_tdr_w3.
// Each scenario task drives a table of control vectors; every vector pushes
// its expected observation {so, select, data, locked} to a scoreboard queue,
// and the task pops and compares it once the DUT has clocked.
// -----------------------------------------------------------------------------
module tb_firebird7_in_gate1_tessent_tdr_w3;

  localparam int WIDTH = 3;

  typedef struct packed {
    logic             so;
    logic             sel;
    logic [WIDTH-1:0] data;
    logic             lock;
  } obs_t;

  // Control vector: {ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si}
  typedef struct packed {
    logic sel;
    logic ce;
    logic se;
    logic ue;
    logic si;
  } ctl_t;

  typedef struct {
    string name;
    obs_t  val;
  } sb_entry_t;

  logic             ijtag_tck = 1'b0;
  logic             ijtag_reset;
  logic             ijtag_sel;
  logic             ijtag_ce;
  logic             ijtag_se;
  logic             ijtag_ue;
  logic             ijtag_si;
  logic             ijtag_so;
  logic [WIDTH-1:0] functional_data_in;
  logic             ijtag_select;
  logic [WIDTH-1:0] ijtag_data_out;
  logic             tdr_locked;

  obs_t      obs;
  sb_entry_t sb[$];
  int        n_vec = 0;
  int        n_err = 0;

  firebird7_in_gate1_tessent_tdr_w3 #(
    .WIDTH      (WIDTH),
    .RESET_DATA (3'b000)
  ) dut (
    .ijtag_tck          (ijtag_tck),
    .ijtag_reset        (ijtag_reset),
    .ijtag_sel          (ijtag_sel),
    .ijtag_ce           (ijtag_ce),
    .ijtag_se           (ijtag_se),
    .ijtag_ue           (ijtag_ue),
    .ijtag_si           (ijtag_si),
    .ijtag_so           (ijtag_so),
    .functional_data_in (functional_data_in),
    .ijtag_select       (ijtag_select),
    .ijtag_data_out     (ijtag_data_out),
    .tdr_locked         (tdr_locked)
  );

  always #5 ijtag_tck = ~ijtag_tck;

  always_comb obs = {ijtag_so, ijtag_select, ijtag_data_out, tdr_locked};

  // Apply one control vector for one tck edge; the expectation goes to the
  // scoreboard and the caller compares once the edge has passed.
  task automatic drive(input ctl_t c, input obs_t exp, input string name);
    sb_entry_t ent;
    {ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si} = c;
    ent.name = name;
    ent.val  = exp;
    sb.push_back(ent);
    @(posedge ijtag_tck);
    #1;
  endtask

  task automatic idle();
    {ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si} = 5'b00000;
  endtask

  task automatic test_reset();
    ctl_t      c[$];
    obs_t      x[$];
    sb_entry_t e;
    // Power-on reset held over two edges.
    ijtag_reset = 1'b1;
    idle();
    functional_data_in = 3'b000;
    e.name = "por";
    e.val  = 6'b0_0_000_0;
    sb.push_back(e);
    repeat (2) @(posedge ijtag_tck);
    #1;
    e = sb.pop_front();
    n_vec++;
    if (obs !== e.val) begin
      n_err++;
      $display("FAIL %s: observed %b expected %b", e.name, obs, e.val);
    end
    ijtag_reset = 1'b0;
    // Load all ones (including lock), then begin another shift.
    c = '{5'b10101, 5'b10101, 5'b10101, 5'b10101, 5'b10101, 5'b10010,
          5'b10101, 5'b10101};
    x = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b100000, 6'b111111,
          6'b111111, 6'b111111};
    for (int i = 0; i < c.size(); i++) begin
      drive(c[i], x[i], $sformatf("reset_load[%0d]", i));
      e = sb.pop_front();
      n_vec++;
      if (obs !== e.val) begin
        n_err++;
        $display("FAIL %s: observed %b expected %b", e.name, obs, e.val);
      end
    end
    // Mid-cycle assertion: outputs must clear without a clock edge.
    #1;
    ijtag_reset = 1'b1;
    e.name = "reset_async";
    e.val  = 6'b0_0_000_0;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    n_vec++;
    if (obs !== e.val) begin
      n_err++;
      $display("FAIL %s: observed %b expected %b", e.name, obs, e.val);
    end
    @(posedge ijtag_tck);
    #1;
    ijtag_reset = 1'b0;
    idle();
  endtask

  task automatic test_shift_update();
    ctl_t      c[$];
    obs_t      x[$];
    sb_entry_t e;
    // si order 1,0,1,1,0 -> SR = 0_1_101, then update.
    c = '{5'b10101, 5'b10100, 5'b10101, 5'b10101, 5'b10100, 5'b10010};
    x = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b100000, 6'b111010};
    for (int i = 0; i < c.size(); i++) begin
      drive(c[i], x[i], $sformatf("shift_update[%0d]", i));
      e = sb.pop_front();
      n_vec++;
      if (obs !== e.val) begin
        n_err++;
        $display("FAIL %s: observed %b expected %b", e.name, obs, e.val);
      end
    end
    idle();
  endtask

  task automatic test_capture();
    ctl_t      c[$];
    obs_t      x[$];
    sb_entry_t e;
    // SR <= {0,1,010}; so reads 0,1,0,1,0.
    functional_data_in = 3'b010;
    c = '{5'b11000, 5'b10100, 5'b10100, 5'b10100, 5'b10100};
    x = '{6'b011010, 6'b111010, 6'b011010, 6'b111010, 6'b011010};
    for (int i = 0; i < c.size(); i++) begin
      drive(c[i], x[i], $sformatf("capture[%0d]", i));
      e = sb.pop_front();
      n_vec++;
      if (obs !== e.val) begin
        n_err++;
        $display("FAIL %s: observed %b expected %b", e.name, obs, e.val);
      end
    end
    idle();
  endtask

  task automatic test_priority();
    ctl_t      c[$];
    obs_t      x[$];
    sb_entry_t e;
    // ce+se with si=1: capture {0,1,110} wins; a shift would give so=1.
    functional_data_in = 3'b110;
    c = '{5'b11101, 5'b10100, 5'b10100, 5'b10100, 5'b10100};
    x = '{6'b011010, 6'b111010, 6'b111010, 6'b111010, 6'b011010};
    for (int i = 0; i < c.size(); i++) begin
      drive(c[i], x[i], $sformatf("priority[%0d]", i));
      e = sb.pop_front();
      n_vec++;
      if (obs !== e.val) begin
        n_err++;
        $display("FAIL %s: observed %b expected %b", e.name, obs, e.val);
      end
    end
    idle();
  endtask

  task automatic test_sel_gating();
    ctl_t      c[$];
    obs_t      x[$];
    sb_entry_t e;
    // Load SR = 1_0_011 (lock pending), then pulse ce/se/ue with sel low:
    // nothing may move, and the SR contents must shift out intact.
    functional_data_in = 3'b111;
    c = '{5'b10101, 5'b10101, 5'b10100, 5'b10100, 5'b10101,
          5'b01000, 5'b00101, 5'b00010, 5'b01111,
          5'b10100, 5'b10100, 5'b10100, 5'b10100};
    x = '{6'b011010, 6'b011010, 6'b011010, 6'b011010, 6'b111010,
          6'b111010, 6'b111010, 6'b111010, 6'b111010,
          6'b111010, 6'b011010, 6'b011010, 6'b111010};
    for (int i = 0; i < c.size(); i++) begin
      drive(c[i], x[i], $sformatf("sel_gating[%0d]", i));
      e = sb.pop_front();
      n_vec++;
      if (obs !== e.val) begin
        n_err++;
        $display("FAIL %s: observed %b expected %b", e.name, obs, e.val);
      end
    end
    idle();
  endtask

  task automatic test_shift_and_update();
    ctl_t      c[$];
    obs_t      x[$];
    sb_entry_t e;
    // SR = 0_1_110, then se+ue (si=1): UR gets pre-shift 0_1_110.
    c = '{5'b10100, 5'b10101, 5'b10101, 5'b10101, 5'b10100,
          5'b10111,
          5'b10100, 5'b10100, 5'b10100, 5'b10100};
    x = '{6'b011010, 6'b011010, 6'b011010, 6'b011010, 6'b011010,
          6'b111100,
          6'b111100, 6'b111100, 6'b011100, 6'b111100};
    for (int i = 0; i < c.size(); i++) begin
      drive(c[i], x[i], $sformatf("shift_and_update[%0d]", i));
      e = sb.pop_front();
      n_vec++;
      if (obs !== e.val) begin
        n_err++;
        $display("FAIL %s: observed %b expected %b", e.name, obs, e.val);
      end
    end
    idle();
  endtask

  task automatic test_lock();
    ctl_t      c[$];
    obs_t      x[$];
    sb_entry_t e;
    // Update 1_1_011, then try 0_0_000, capture (lock reads back as 1),
    // and a final update: the update stage must never change.
    functional_data_in = 3'b100;
    c = '{5'b10101, 5'b10101, 5'b10100, 5'b10101, 5'b10101,
          5'b10010,
          5'b10100, 5'b10100, 5'b10100, 5'b10100, 5'b10100,
          5'b10010,
          5'b11000, 5'b10100, 5'b10100, 5'b10100, 5'b10100,
          5'b10010};
    x = '{6'b011100, 6'b011100, 6'b011100, 6'b011100, 6'b111100,
          6'b110111,
          6'b110111, 6'b010111, 6'b110111, 6'b110111, 6'b010111,
          6'b010111,
          6'b010111, 6'b010111, 6'b110111, 6'b110111, 6'b110111,
          6'b110111};
    for (int i = 0; i < c.size(); i++) begin
      drive(c[i], x[i], $sformatf("lock[%0d]", i));
      e = sb.pop_front();
      n_vec++;
      if (obs !== e.val) begin
        n_err++;
        $display("FAIL %s: observed %b expected %b", e.name, obs, e.val);
      end
    end
    idle();
    // Only reset releases the lock.
    ijtag_reset = 1'b1;
    e.name = "lock_reset";
    e.val  = 6'b0_0_000_0;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    n_vec++;
    if (obs !== e.val) begin
      n_err++;
      $display("FAIL %s: observed %b expected %b", e.name, obs, e.val);
    end
    @(posedge ijtag_tck);
    #1;
    ijtag_reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_shift_update();
    test_capture();
    test_priority();
    test_sel_gating();
    test_shift_and_update();
    test_lock();
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: observed %0d entries expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/firebird7_in_gate1_tessent_tdr_w3.md
Name: firebird7_in_gate1_tessent_tdr_w3

Overview:
- IJTAG test data register (TDR) sitting directly upstream of the 3-bit IJTAG data mux.
- Produces that mux's ijtag_select and ijtag_data_in from a shift/capture/update register on the IJTAG scan path.
- Captures the mux's functional input for observation.
- Provides a lock bit that freezes the update stage until reset.

Parameters:
- WIDTH, 3, data bits driven to the mux. Shift register length = WIDTH+2.
- RESET_DATA, 3'b000, update-register data value after reset (WIDTH bits).

Ports:
- ijtag_tck  input  1  IJTAG clock; all state updates on the rising edge.
- ijtag_reset  input  1  asynchronous, active-high reset.
- ijtag_sel  input  1  this TDR is on the active scan path.
- ijtag_ce  input  1  capture enable.
- ijtag_se  input  1  shift enable.
- ijtag_ue  input  1  update enable.
- ijtag_si  input  1  scan in.
- ijtag_so  output  1  scan out = shift-register bit 0.
- functional_data_in  input  WIDTH  functional value, captured for observation.
- ijtag_select  output  1  update-stage select bit, goes to the mux select.
- ijtag_data_out  output  WIDTH  update-stage data, goes to the mux ijtag_data_in.
- tdr_locked  output  1  update-stage lock bit.

Behaviour:
- Shift register layout, SR[WIDTH+1:0]:
  - SR[WIDTH+1] = lock
  - SR[WIDTH] = select
  - SR[WIDTH-1:0] = data
- Update register UR has the same layout; outputs are driven directly from UR with no combinational path from SR.
- Reset (async assert, any cycle, including mid-shift):
  - SR = 0.
  - UR.data = RESET_DATA, UR.select = 0, UR.lock = 0.
  - Outputs: ijtag_so = 0, ijtag_select = 0, ijtag_data_out = RESET_DATA, tdr_locked = 0.
  - Deassertion is synchronous to ijtag_tck by the integrator; the block takes no action on it.
- Inactive: with ijtag_sel = 0, SR and UR hold regardless of ce/se/ue.
- Capture (ijtag_sel & ijtag_ce):
  - SR <= {UR.lock, UR.select, functional_data_in}.
- Shift (ijtag_sel & ijtag_se & ~ijtag_ce):
  - SR <= {ijtag_si, SR[WIDTH+1:1]}, so LSB exits first.
  - ijtag_so shows the new SR[0] one edge later.
- Capture has priority over shift when both are asserted; shift does not occur that edge.
- Update (ijtag_sel & ijtag_ue):
  - If UR.lock = 0: UR <= SR.
  - If UR.lock = 1: UR holds entirely. Lock cannot be cleared by scan; only reset clears it.
  - Update samples SR as it stood before this edge. A simultaneous capture or shift on the same edge still modifies SR, and the update sees the pre-edge value.
  - Writing lock = 1 via update takes effect together with the select/data written in the same update. The lock then blocks subsequent updates.
- Latency:
  - Update: UR and outputs change 1 tck after the ue edge.
  - Capture: value is visible at ijtag_so 1 tck after the capture edge (bit 0).
- No internal FSM beyond the lock state, which has two states:
  - UNLOCKED → LOCKED on an update with SR[WIDTH+1] = 1.
  - LOCKED → UNLOCKED on reset only.
- Scan length seen by the tool: WIDTH+2 bits.

Test Plan:
- Reset mid-shift: shift 2 bits, assert ijtag_reset for 1 tck → ijtag_select = 0, ijtag_data_out = 3'b000, tdr_locked = 0, ijtag_so = 0 immediately (async).
- Shift then update: shift in SR = 5'b0_1_101 (si order 1,0,1,1,0), pulse ue → ijtag_select = 1, ijtag_data_out = 3'b101, tdr_locked = 0 one tck after ue.
- Capture and observe: UR = {0,1,101}, functional_data_in = 3'b010, pulse ce, shift 5 → so sequence 0,1,0,1,0.
- Lock: update 5'b1_1_011, then shift/update 5'b0_0_000 → outputs stay select = 1, data = 3'b011, locked = 1. Reset → all cleared.
- Priority/sel gating:
  - ce & se on the same edge → SR equals the captured value; no shift occurs.
  - ijtag_sel = 0 with ce/se/ue pulses → SR, UR and outputs unchanged.
- Simultaneous shift+update: SR = 5'b0_1_110, assert se & ue together → UR = 5'b0_1_110 (pre-shift value) while SR shifts.
